// File: rtl/lightpen_pkg.sv
// lightpen_pkg: shared LED matrix geometry and one-hot index decoding
package lightpen_pkg;
  localparam int ROW_N = 8;
  localparam int COL_N = 8;
  localparam int IDX_W = 3;
  typedef struct packed {
    logic ok;
    logic [IDX_W-1:0] idx;
  } oh_t;
  function automatic oh_t onehot8_to_idx(input logic [7:0] v);
    oh_t r;
    int n;
    r = '0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        r.idx = IDX_W'(i);
        n++;
      end
    end
    r.ok = (n == 1);
    return r;
  endfunction
endpackage

// File: rtl/pen_sync.sv
// pen_sync: multi-stage synchronizer for the asynchronous pen input
module pen_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s <= '0;
    else s <= {s[STAGES-2:0], d};
  end
  assign q = s[STAGES-1];
endmodule

// File: rtl/pen_locator.sv
// pen_locator: measures pen light per LED slot and reports the brightest slot once per frame
module pen_locator
  import lightpen_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYCLES = 8,
  parameter int MIN_HITS     = 16,
  parameter int MISS_FRAMES  = 3,
  parameter int CNT_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_N-1:0] led_row,
  input  logic [COL_N-1:0] led_col,
  input  logic             pen_in,
  output logic             pen_valid,
  output logic [IDX_W-1:0] pen_x,
  output logic [IDX_W-1:0] pen_y,
  output logic [CNT_W-1:0] pen_level,
  output logic             frame_strobe,
  output logic             scan_err
);
  localparam int SW = $clog2(BLANK_CYCLES + 1);
  localparam int MW = $clog2(MISS_FRAMES + 1);
  logic pen_s, slot_ok, frame_started, slot_start, frame_end, sample, upd, pos_ok;
  logic [ROW_N+COL_N-1:0] pos_q;
  logic [SW-1:0] slot_cnt, slot_inc;
  logic [CNT_W-1:0] hit_cnt, hit_nxt, best_cnt, bc;
  logic [IDX_W-1:0] cur_x, cur_y, best_x, best_y, bx, by;
  logic [MW-1:0] miss_cnt, miss_inc;
  oh_t rdec, cdec;
  pen_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pen_in),
    .q  (pen_s)
  );
  always_comb begin
    rdec = onehot8_to_idx(led_row);
    cdec = onehot8_to_idx(led_col);
    pos_ok = rdec.ok && cdec.ok;
    slot_start = {led_row, led_col} != pos_q;
    frame_end = slot_start && led_row == 8'h01 && led_col == 8'h01;
    slot_inc = (slot_cnt == SW'(BLANK_CYCLES)) ? slot_cnt : slot_cnt + 1'b1;
    sample = slot_ok && pen_s && slot_cnt == SW'(BLANK_CYCLES);
    hit_nxt = (sample && hit_cnt != '1) ? hit_cnt + 1'b1 : hit_cnt;
    upd = slot_ok && hit_nxt > best_cnt;
    bc = upd ? hit_nxt : best_cnt;
    bx = upd ? cur_x : best_x;
    by = upd ? cur_y : best_y;
    miss_inc = (miss_cnt == MW'(MISS_FRAMES)) ? miss_cnt : miss_cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      slot_cnt <= '0;
      hit_cnt <= '0;
      slot_ok <= 1'b0;
      cur_x <= '0;
      cur_y <= '0;
      best_cnt <= '0;
      best_x <= '0;
      best_y <= '0;
      miss_cnt <= MW'(MISS_FRAMES);
      frame_started <= 1'b0;
      pen_valid <= 1'b0;
      pen_x <= '0;
      pen_y <= '0;
      pen_level <= '0;
      frame_strobe <= 1'b0;
      scan_err <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      scan_err <= 1'b0;
      if (slot_start) begin
        pos_q <= {led_row, led_col};
        slot_cnt <= '0;
        hit_cnt <= '0;
        slot_ok <= pos_ok;
        cur_x <= cdec.idx;
        cur_y <= rdec.idx;
        scan_err <= !pos_ok;
        best_cnt <= frame_end ? '0 : bc;
        best_x <= frame_end ? '0 : bx;
        best_y <= frame_end ? '0 : by;
        if (frame_end && !frame_started) frame_started <= 1'b1;
        if (frame_end && frame_started) begin
          frame_strobe <= 1'b1;
          if (bc >= CNT_W'(MIN_HITS)) begin
            pen_x <= bx;
            pen_y <= by;
            pen_level <= bc;
            pen_valid <= 1'b1;
            miss_cnt <= '0;
          end else begin
            miss_cnt <= miss_inc;
            if (miss_inc == MW'(MISS_FRAMES)) pen_valid <= 1'b0;
          end
        end
      end else begin
        slot_cnt <= slot_inc;
        hit_cnt <= hit_nxt;
      end
    end
  end
endmodule
